// File: rtl/dc_countdown_timer_if.sv
// Load/control strobes and time/status outputs of the countdown timer.
// master drives the load digits and controls; slave is the timer itself.
interface dc_countdown_timer_if;
  logic       load;
  logic [3:0] ld_sec_unit;
  logic [2:0] ld_sec_ten;
  logic [3:0] ld_min_unit;
  logic [2:0] ld_min_ten;
  logic [3:0] ld_hour_unit;
  logic [1:0] ld_hour_ten;
  logic       start;
  logic       stop;
  logic       tick;

  logic [3:0] sec_unit;
  logic [2:0] sec_ten;
  logic [3:0] min_unit;
  logic [2:0] min_ten;
  logic [3:0] hour_unit;
  logic [1:0] hour_ten;
  logic       running;
  logic       done;
  logic       load_err;

  modport master (
    output load, ld_sec_unit, ld_sec_ten, ld_min_unit, ld_min_ten,
           ld_hour_unit, ld_hour_ten, start, stop, tick,
    input  sec_unit, sec_ten, min_unit, min_ten, hour_unit, hour_ten,
           running, done, load_err
  );

  modport slave (
    input  load, ld_sec_unit, ld_sec_ten, ld_min_unit, ld_min_ten,
           ld_hour_unit, ld_hour_ten, start, stop, tick,
    output sec_unit, sec_ten, min_unit, min_ten, hour_unit, hour_ten,
           running, done, load_err
  );
endinterface

// File: rtl/dc_countdown_timer.sv
// BCD HH:MM:SS countdown timer with IDLE/RUN/EXPIRED control, a one-cycle
// done pulse on reaching zero and a one-cycle load_err pulse on bad loads.
module dc_countdown_timer (
  input  logic                  clk,
  input  logic                  reset,
  dc_countdown_timer_if.slave   tmr
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] sec_unit_q;
  logic [2:0] sec_ten_q;
  logic [3:0] min_unit_q;
  logic [2:0] min_ten_q;
  logic [3:0] hour_unit_q;
  logic [1:0] hour_ten_q;
  logic       running_q;
  logic       done_q;
  logic       load_err_q;

  logic [3:0] sec_unit_d;
  logic [2:0] sec_ten_d;
  logic [3:0] min_unit_d;
  logic [2:0] min_ten_d;
  logic [3:0] hour_unit_d;
  logic [1:0] hour_ten_d;

  logic load_valid;
  logic count_zero;
  logic count_one;
  logic borrow_su, borrow_st, borrow_mu, borrow_mt, borrow_hu;

  // Any digit out of range, or 24..29 hours, makes the whole load invalid.
  assign load_valid = (tmr.ld_sec_unit  <= 4'd9) &&
                      (tmr.ld_sec_ten   <= 3'd5) &&
                      (tmr.ld_min_unit  <= 4'd9) &&
                      (tmr.ld_min_ten   <= 3'd5) &&
                      (tmr.ld_hour_unit <= 4'd9) &&
                      (tmr.ld_hour_ten  <= 2'd2) &&
                      !((tmr.ld_hour_ten == 2'd2) && (tmr.ld_hour_unit > 4'd3));

  assign count_zero = (sec_unit_q == 4'd0) && (sec_ten_q == 3'd0) &&
                      (min_unit_q == 4'd0) && (min_ten_q == 3'd0) &&
                      (hour_unit_q == 4'd0) && (hour_ten_q == 2'd0);

  assign count_one  = (sec_unit_q == 4'd1) && (sec_ten_q == 3'd0) &&
                      (min_unit_q == 4'd0) && (min_ten_q == 3'd0) &&
                      (hour_unit_q == 4'd0) && (hour_ten_q == 2'd0);

  // Ripple borrow: each digit wraps only when every lower digit is zero.
  assign borrow_su = (sec_unit_q  == 4'd0);
  assign borrow_st = borrow_su && (sec_ten_q   == 3'd0);
  assign borrow_mu = borrow_st && (min_unit_q  == 4'd0);
  assign borrow_mt = borrow_mu && (min_ten_q   == 3'd0);
  assign borrow_hu = borrow_mt && (hour_unit_q == 4'd0);

  always_comb begin
    sec_unit_d  = borrow_su ? 4'd9 : sec_unit_q - 4'd1;
    sec_ten_d   = sec_ten_q;
    min_unit_d  = min_unit_q;
    min_ten_d   = min_ten_q;
    hour_unit_d = hour_unit_q;
    hour_ten_d  = hour_ten_q;
    if (borrow_su) begin
      sec_ten_d = borrow_st ? 3'd5 : sec_ten_q - 3'd1;
    end
    if (borrow_st) begin
      min_unit_d = borrow_mu ? 4'd9 : min_unit_q - 4'd1;
    end
    if (borrow_mu) begin
      min_ten_d = borrow_mt ? 3'd5 : min_ten_q - 3'd1;
    end
    if (borrow_mt) begin
      hour_unit_d = borrow_hu ? 4'd9 : hour_unit_q - 4'd1;
    end
    // Count never goes below zero, so hour_ten is nonzero whenever this fires.
    if (borrow_hu) begin
      hour_ten_d = hour_ten_q - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      sec_unit_q  <= 4'd0;
      sec_ten_q   <= 3'd0;
      min_unit_q  <= 4'd0;
      min_ten_q   <= 3'd0;
      hour_unit_q <= 4'd0;
      hour_ten_q  <= 2'd0;
      running_q   <= 1'b0;
      done_q      <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      load_err_q <= 1'b0;
      if (tmr.load) begin
        if (load_valid) begin
          sec_unit_q  <= tmr.ld_sec_unit;
          sec_ten_q   <= tmr.ld_sec_ten;
          min_unit_q  <= tmr.ld_min_unit;
          min_ten_q   <= tmr.ld_min_ten;
          hour_unit_q <= tmr.ld_hour_unit;
          hour_ten_q  <= tmr.ld_hour_ten;
          state_q     <= IDLE;
          running_q   <= 1'b0;
        end else begin
          load_err_q <= 1'b1;
        end
      end else if (tmr.stop) begin
        if (state_q == RUN) begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      end else if (tmr.start) begin
        if ((state_q == IDLE) && !count_zero) begin
          state_q   <= RUN;
          running_q <= 1'b1;
        end
      end else if (tmr.tick && (state_q == RUN)) begin
        sec_unit_q  <= sec_unit_d;
        sec_ten_q   <= sec_ten_d;
        min_unit_q  <= min_unit_d;
        min_ten_q   <= min_ten_d;
        hour_unit_q <= hour_unit_d;
        hour_ten_q  <= hour_ten_d;
        if (count_one) begin
          state_q   <= EXPIRED;
          running_q <= 1'b0;
          done_q    <= 1'b1;
        end
      end
    end
  end

  assign tmr.sec_unit  = sec_unit_q;
  assign tmr.sec_ten   = sec_ten_q;
  assign tmr.min_unit  = min_unit_q;
  assign tmr.min_ten   = min_ten_q;
  assign tmr.hour_unit = hour_unit_q;
  assign tmr.hour_ten  = hour_ten_q;
  assign tmr.running   = running_q;
  assign tmr.done      = done_q;
  assign tmr.load_err  = load_err_q;

endmodule

// File: doc/dc_countdown_timer.md
# dc_countdown_timer

BCD countdown timer that counts HH:MM:SS down to 00:00:00 and pulses a completion flag. It is the down-counting counterpart of the team's up-counting digital clock and uses the same digit split and widths. The clock's time outputs can drive its load inputs directly. It sits beside the clock in the timekeeping datapath and feeds the display and alarm logic.

## Interface
- No parameters. Digit widths are fixed to match the clock digit bus.
- clk  in  1  system clock; all state changes on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- load  in  1  single-cycle strobe; captures the ld_* digits.
- ld_sec_unit  in  4  seconds units, 0-9.
- ld_sec_ten  in  3  seconds tens, 0-5.
- ld_min_unit  in  4  minutes units, 0-9.
- ld_min_ten  in  3  minutes tens, 0-5.
- ld_hour_unit  in  4  hours units, 0-9 (0-3 when ld_hour_ten=2).
- ld_hour_ten  in  2  hours tens, 0-2.
- start  in  1  begin or resume counting.
- stop  in  1  pause counting; digits hold.
- tick  in  1  one-second enable; one decrement per posedge with tick=1 while running.
- sec_unit  out  4  current seconds units.
- sec_ten  out  3  current seconds tens.
- min_unit  out  4  current minutes units.
- min_ten  out  3  current minutes tens.
- hour_unit  out  4  current hours units.
- hour_ten  out  2  current hours tens.
- running  out  1  high while in RUN.
- done  out  1  one-cycle pulse on reaching zero.
- load_err  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, EXPIRED. Reset → IDLE.
- Priority per edge: reset > load > stop > start > tick.
- Reset: all digits 0, state IDLE, running=0, done=0, load_err=0.
- Load, valid value (all digits in range, total ≤ 23:59:59):
  - Digits take the ld_* values; state → IDLE.
  - Accepted from any state, including mid-RUN; a tick on the same edge is ignored.
- Load, invalid value (any unit digit >9, any ten digit over its limit, hour_ten=3, or hour_ten=2 with hour_unit>3):
  - Digits and state are unchanged; load_err=1 for one cycle.
- stop: RUN → IDLE, digits hold. No effect in IDLE or EXPIRED.
- start:
  - IDLE with nonzero count → RUN.
  - IDLE with zero count: ignored, no done.
  - EXPIRED: ignored until a valid load.
  - RUN: no effect.
- Decrement in RUN on tick=1, digit-serial borrow chain:
  - sec_unit 0 → 9 and borrow, else −1.
  - sec_ten 0 → 5 and borrow.
  - min_unit 0 → 9 and borrow.
  - min_ten 0 → 5 and borrow.
  - hour_unit 0 → 9 and borrow into hour_ten −1.
  - No hour wrap is possible, because counting stops at zero.
- Zero reached: on the edge where the count goes from 00:00:01 to 00:00:00, state → EXPIRED and done=1 for that one cycle. Digits stay at 0.
- Digit outputs never leave their legal ranges.

## Timing
- All outputs are registered. Digits change one cycle after the sampling edge (visible immediately after the posedge where load, or tick in RUN, is high).
- running reflects the state register. start to running=1 takes 1 cycle. A tick on the same edge as start is not counted.
- done and load_err are single-cycle pulses, each asserted for exactly one clk period. done is high in the first cycle of EXPIRED.
- Back-to-back ticks decrement on every edge; the full borrow chain resolves in one cycle (e.g. 10:00:00 → 09:59:59).
- Reset on the same edge as any other input wins; no done pulse is produced.

## Test plan
- Reset, then load 00:00:03, start, tick every cycle. Required:
  - Outputs step 02, 01, 00.
  - done pulses on the edge where the count becomes 00:00:00.
  - running drops; state is EXPIRED.
  - Further ticks leave the count at 0 and produce no new done.
- Borrow chain: load 10:00:00, start, one tick → 09:59:59 exactly one cycle later.
- Load 23:59:59, start, one tick → 23:59:58. Then load 24:00:00 → load_err pulses for one cycle and digits stay at the prior value.
- Pause/resume: load 00:01:00, start, two ticks (→ 00:00:58), stop, three ticks (count holds at 00:00:58, running=0), start, one tick → 00:00:57.
- Mid-run load: in RUN at 00:00:05, assert load 00:02:00 together with tick → digits 00:02:00, state IDLE, no decrement.
- Simultaneous events: reset asserted together with load, start and tick → all digits 0, running=0, done=0. Then start with zero count → running stays 0 and no done.
